// File: rtl/rom_image_loader_if.sv
// ---------------------------------------------------------------------------
// rom_image_loader_if
// Purpose : Wishbone bus bundle between the boot image loader (master) and
//           the console ROM's wishbone slave port.
// Signals : wb_adr_o [15:0] byte address          (master -> slave)
//           wb_dat_o [7:0]  write data            (master -> slave)
//           wb_dat_i [7:0]  read data, valid w/ ack (slave -> master)
//           wb_we_o         write enable          (master -> slave)
//           wb_sel_o [0:0]  byte select           (master -> slave)
//           wb_stb_o        strobe                (master -> slave)
//           wb_cyc_o        cycle                 (master -> slave)
//           wb_ack_i        acknowledge           (slave -> master)
// ---------------------------------------------------------------------------
interface rom_image_loader_if;
    logic [15:0] wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic [7:0]  wb_dat_i;
    logic        wb_we_o;
    logic [0:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/rom_image_loader.sv
// ---------------------------------------------------------------------------
// rom_image_loader
// Purpose : Boot-time wishbone master. Takes a byte stream and writes each
//           byte to its ROM location (write pass) or reads the location back
//           and counts differences (verify pass). Keeps a 16-bit running sum
//           of the accepted stream bytes for the boot controller.
// Params  : INTERLEAVE  1: byte n -> base + ((n&1)<<12) + (n>>1); 0: base + n
//           WB_TIMEOUT  bus cycles to wait for ack before giving up (1..255)
// Ports   : clk, reset_n        clock, async active-low reset
//           start, verify       pass request and mode (sampled with start)
//           base_adr, length    image byte-0 address and byte count
//           s_data/s_valid/s_ready  stream input handshake
//           busy, done, error   pass status levels
//           mismatch_cnt        verify differences (saturating)
//           checksum            sum of accepted bytes mod 2^16
//           wb                  wishbone master modport
// ---------------------------------------------------------------------------
module rom_image_loader #(
    parameter int INTERLEAVE = 1,
    parameter int WB_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        verify,
    input  logic [15:0] base_adr,
    input  logic [15:0] length,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] mismatch_cnt,
    output logic [15:0] checksum,
    rom_image_loader_if.master wb
);

    // Timer value on the last permitted wait cycle; the timer starts at 0
    // on BUS entry, so BUS lasts exactly WB_TIMEOUT cycles without an ack.
    localparam logic [7:0] TMO_LAST = 8'(WB_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_BUS   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_verify;
    logic [15:0] r_base;
    logic [15:0] r_length;
    logic [15:0] r_count;
    logic [7:0]  r_byte;
    logic [15:0] r_checksum;
    logic [15:0] r_mismatch;
    logic        r_done;
    logic        r_error;
    logic [15:0] r_adr;
    logic [7:0]  r_dat;
    logic        r_we;
    logic [0:0]  r_sel;
    logic        r_stb;
    logic        r_cyc;
    logic [7:0]  r_tmo;

    logic        w_start_acc;
    logic        w_take;
    logic        w_ack;
    logic        w_wait;
    logic        w_timeout;
    logic        w_last;
    logic [15:0] w_count_inc;
    logic [15:0] w_adr;

    // Event decode shared by the FSM and the datapath.
    always_comb begin
        w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                (r_state == ST_ERROR));
        w_take      = (r_state == ST_FETCH) && s_valid;
        w_ack       = (r_state == ST_BUS) && wb.wb_ack_i;
        w_timeout   = (r_state == ST_BUS) && !wb.wb_ack_i && (r_tmo == TMO_LAST);
        w_wait      = (r_state == ST_BUS) && !wb.wb_ack_i && (r_tmo != TMO_LAST);
        w_count_inc = r_count + 16'd1;
        w_last      = (w_count_inc == r_length);
    end

    // Address of stream byte r_count; the interleaved form puts even bytes in
    // the low bank and odd bytes 4 KiB higher, all arithmetic wrapping at 16 bits.
    always_comb begin
        if (INTERLEAVE != 0) begin
            w_adr = r_base + {3'b000, r_count[0], 12'h000} + {1'b0, r_count[15:1]};
        end else begin
            w_adr = r_base + r_count;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    if (length == 16'd0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_FETCH: begin
                if (s_valid) begin
                    w_state_nxt = ST_BUS;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_BUS: begin
                if (wb.wb_ack_i) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_state_nxt = ST_BUS;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pass parameters, counters and the registered wishbone outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_verify   <= 1'b0;
            r_base     <= 16'h0000;
            r_length   <= 16'h0000;
            r_count    <= 16'h0000;
            r_byte     <= 8'h00;
            r_checksum <= 16'h0000;
            r_mismatch <= 16'h0000;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_adr      <= 16'h0000;
            r_dat      <= 8'h00;
            r_we       <= 1'b0;
            r_sel      <= 1'b0;
            r_stb      <= 1'b0;
            r_cyc      <= 1'b0;
            r_tmo      <= 8'h00;
        end else begin
            if (w_start_acc) begin
                r_verify   <= verify;
                r_we       <= !verify;
                r_base     <= base_adr;
                r_length   <= length;
                r_count    <= 16'h0000;
                r_checksum <= 16'h0000;
                r_mismatch <= 16'h0000;
                r_done     <= (length == 16'd0);
                r_error    <= 1'b0;
            end
            if (w_take) begin
                r_byte     <= s_data;
                r_checksum <= r_checksum + {8'h00, s_data};
                r_adr      <= w_adr;
                r_dat      <= s_data;
                r_cyc      <= 1'b1;
                r_stb      <= 1'b1;
                r_sel      <= 1'b1;
                r_tmo      <= 8'h00;
            end
            if (w_ack) begin
                r_cyc   <= 1'b0;
                r_stb   <= 1'b0;
                r_sel   <= 1'b0;
                r_count <= w_count_inc;
                if (r_verify && (wb.wb_dat_i != r_byte) && (r_mismatch != 16'hFFFF)) begin
                    r_mismatch <= r_mismatch + 16'd1;
                end
                if (w_last) begin
                    r_done <= 1'b1;
                end
            end
            if (w_wait) begin
                r_tmo <= r_tmo + 8'd1;
            end
            if (w_timeout) begin
                r_cyc   <= 1'b0;
                r_stb   <= 1'b0;
                r_sel   <= 1'b0;
                r_error <= 1'b1;
            end
        end
    end

    assign s_ready      = (r_state == ST_FETCH);
    assign busy         = (r_state == ST_FETCH) || (r_state == ST_BUS);
    assign done         = r_done;
    assign error        = r_error;
    assign mismatch_cnt = r_mismatch;
    assign checksum     = r_checksum;

    assign wb.wb_adr_o  = r_adr;
    assign wb.wb_dat_o  = r_dat;
    assign wb.wb_we_o   = r_we;
    assign wb.wb_sel_o  = r_sel;
    assign wb.wb_stb_o  = r_stb;
    assign wb.wb_cyc_o  = r_cyc;

endmodule

// File: tb/tb_rom_image_loader.sv
// ---------------------------------------------------------------------------
// tb_rom_image_loader
// Directed bench for rom_image_loader: a byte-stream source, a wishbone ROM
// slave with configurable ack latency (or no ack), a transaction-level model
// of the expected bus traffic and status, and literal end-of-pass checks.
// ---------------------------------------------------------------------------
module tb_rom_image_loader;

    localparam int WB_TMO = 255;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        verify = 1'b0;
    logic [15:0] base_adr = 16'h0000;
    logic [15:0] length = 16'h0000;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] mismatch_cnt;
    logic [15:0] checksum;

    rom_image_loader_if wb();

    rom_image_loader #(.INTERLEAVE(1), .WB_TIMEOUT(WB_TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .verify       (verify),
        .base_adr     (base_adr),
        .length       (length),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .mismatch_cnt (mismatch_cnt),
        .checksum     (checksum),
        .wb           (wb.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- wishbone ROM slave ----------------
    logic [7:0] mem [0:65535];
    bit         never_ack = 1'b0;
    int         ack_lat = 1;
    int         n_wr = 0;
    int         n_rd = 0;
    int         cyc_cycles = 0;

    initial begin
        bit          commit;
        bit          c_we;
        bit          nxt_ack;
        logic [15:0] c_adr;
        logic [7:0]  c_dat;
        logic [7:0]  nxt_dat;
        int          wcnt;
        wcnt = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        wb.wb_ack_i = 1'b0;
        wb.wb_dat_i = 8'h00;
        forever begin
            @(negedge clk);
            commit  = 1'b0;
            nxt_ack = 1'b0;
            nxt_dat = 8'h00;
            c_we    = 1'b0;
            c_adr   = 16'h0000;
            c_dat   = 8'h00;
            if (wb.wb_cyc_o && wb.wb_stb_o) begin
                cyc_cycles++;
                if (wb.wb_ack_i) begin
                    commit = 1'b1;
                    c_we   = wb.wb_we_o;
                    c_adr  = wb.wb_adr_o;
                    c_dat  = wb.wb_dat_o;
                    wcnt   = 0;
                end else begin
                    wcnt++;
                    if (!never_ack && wcnt >= ack_lat) begin
                        nxt_ack = 1'b1;
                        nxt_dat = mem[wb.wb_adr_o];
                    end
                end
            end else begin
                wcnt = 0;
            end
            @(posedge clk);
            #1;
            if (commit) begin
                if (c_we) begin
                    mem[c_adr] = c_dat;
                    n_wr++;
                end else begin
                    n_rd++;
                end
            end
            wb.wb_ack_i = nxt_ack;
            wb.wb_dat_i = nxt_dat;
        end
    end

    // ---------------- stream source ----------------
    logic [7:0] tx_q[$];
    int         tx_gap = 0;

    initial begin
        int gap_cnt;
        bit acc;
        gap_cnt = 0;
        forever begin
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc && tx_q.size() > 0) begin
                void'(tx_q.pop_front());
                gap_cnt = tx_gap;
            end else if (gap_cnt > 0) begin
                gap_cnt--;
            end
            if (reset_n && tx_q.size() > 0 && gap_cnt == 0) begin
                s_valid = 1'b1;
                s_data  = tx_q[0];
            end else begin
                s_valid = 1'b0;
                s_data  = 8'h00;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic [15:0] adr;
        logic [7:0]  dat;
        logic        we;
    } txn_t;

    txn_t        exp_q[$];
    bit          m_active, m_verify, m_done, m_error;
    logic [15:0] m_base, m_len, m_acc, m_cmp, m_csum, m_mism;
    int          m_wait;

    function automatic logic [15:0] mdl_adr(input logic [15:0] base, input logic [15:0] n);
        return base + ((n & 16'd1) << 12) + (n >> 1);
    endfunction

    initial begin
        bit   pend;
        txn_t t;
        m_active = 1'b0; m_verify = 1'b0; m_done = 1'b0; m_error = 1'b0;
        m_base = 16'h0; m_len = 16'h0; m_acc = 16'h0; m_cmp = 16'h0;
        m_csum = 16'h0; m_mism = 16'h0; m_wait = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_active = 1'b0; m_verify = 1'b0; m_done = 1'b0; m_error = 1'b0;
                m_acc = 16'h0; m_cmp = 16'h0; m_csum = 16'h0; m_mism = 16'h0;
                m_wait = 0;
                exp_q.delete();
            end else begin
                pend = (exp_q.size() > 0);
                chk("m_busy",     32'(busy),         32'(m_active));
                chk("m_done",     32'(done),         32'(m_done));
                chk("m_error",    32'(error),        32'(m_error));
                chk("m_checksum", 32'(checksum),     32'(m_csum));
                chk("m_mismatch", 32'(mismatch_cnt), 32'(m_mism));
                chk("m_s_ready",  32'(s_ready),      32'(m_active && !pend));
                chk("m_cyc",      32'(wb.wb_cyc_o),  32'(pend));
                chk("m_stb",      32'(wb.wb_stb_o),  32'(pend));
                if (pend) begin
                    chk("m_adr", 32'(wb.wb_adr_o), 32'(exp_q[0].adr));
                    chk("m_dat", 32'(wb.wb_dat_o), 32'(exp_q[0].dat));
                    chk("m_we",  32'(wb.wb_we_o),  32'(exp_q[0].we));
                    chk("m_sel", 32'(wb.wb_sel_o), 32'h1);
                end
                // what happens at the coming clock edge
                if (!m_active) begin
                    if (start) begin
                        m_verify = verify;
                        m_base   = base_adr;
                        m_len    = length;
                        m_acc    = 16'h0;
                        m_cmp    = 16'h0;
                        m_csum   = 16'h0;
                        m_mism   = 16'h0;
                        m_error  = 1'b0;
                        m_done   = (length == 16'h0);
                        m_active = (length != 16'h0);
                        exp_q.delete();
                    end
                end else if (!pend) begin
                    if (s_valid) begin
                        t.adr = mdl_adr(m_base, m_acc);
                        t.dat = s_data;
                        t.we  = !m_verify;
                        exp_q.push_back(t);
                        m_csum = m_csum + {8'h00, s_data};
                        m_acc  = m_acc + 16'd1;
                        m_wait = 0;
                    end
                end else if (wb.wb_ack_i) begin
                    if (m_verify && wb.wb_dat_i != exp_q[0].dat && m_mism != 16'hFFFF)
                        m_mism = m_mism + 16'd1;
                    void'(exp_q.pop_front());
                    m_cmp = m_cmp + 16'd1;
                    if (m_cmp == m_len) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end else begin
                    m_wait++;
                    if (m_wait == WB_TMO) begin
                        m_active = 1'b0;
                        m_error  = 1'b1;
                        exp_q.delete();
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic do_start(input bit v, input logic [15:0] b, input logic [15:0] l);
        @(posedge clk);
        #2;
        verify   = v;
        base_adr = b;
        length   = l;
        start    = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int max);
        int k;
        k = 0;
        while (!(done || error) && k < max) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_finished"}, 32'(done || error), 32'h1);
    endtask

    initial begin
        int wr0, rd0, k;
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, rd0, k;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy",    32'(busy),          32'h0);
        chk("rst_done",    32'(done),          32'h0);
        chk("rst_error",   32'(error),         32'h0);
        chk("rst_s_ready", 32'(s_ready),       32'h0);
        chk("rst_cyc",     32'(wb.wb_cyc_o),   32'h0);
        chk("rst_stb",     32'(wb.wb_stb_o),   32'h0);
        chk("rst_we",      32'(wb.wb_we_o),    32'h0);
        chk("rst_sel",     32'(wb.wb_sel_o),   32'h0);
        chk("rst_adr",     32'(wb.wb_adr_o),   32'h0);
        chk("rst_dat",     32'(wb.wb_dat_o),   32'h0);
        chk("rst_mism",    32'(mismatch_cnt),  32'h0);
        chk("rst_csum",    32'(checksum),      32'h0);
        reset_n = 1'b1;

        // write pass, interleaved banks
        tx_gap = 0; ack_lat = 1;
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        wr0 = n_wr;
        do_start(1'b0, 16'h0000, 16'd4);
        wait_end("t1", 100);
        chk("t1_mem0000", 32'(mem[16'h0000]), 32'h11);
        chk("t1_mem1000", 32'(mem[16'h1000]), 32'h22);
        chk("t1_mem0001", 32'(mem[16'h0001]), 32'h33);
        chk("t1_mem1001", 32'(mem[16'h1001]), 32'h44);
        chk("t1_csum",    32'(checksum),      32'h00AA);
        chk("t1_done",    32'(done),          32'h1);
        chk("t1_error",   32'(error),         32'h0);
        chk("t1_writes",  32'(n_wr - wr0),    32'd4);

        // verify pass with one corrupted stream byte
        tx_q = '{8'h11, 8'h22, 8'h30, 8'h44};
        rd0 = n_rd;
        do_start(1'b1, 16'h0000, 16'd4);
        wait_end("t2", 100);
        chk("t2_reads", 32'(n_rd - rd0),   32'd4);
        chk("t2_mism",  32'(mismatch_cnt), 32'd1);
        chk("t2_csum",  32'(checksum),     32'h00A7);
        chk("t2_done",  32'(done),         32'h1);
        chk("t2_we",    32'(wb.wb_we_o),   32'h0);

        // gapped stream and a slow slave
        tx_gap = 4; ack_lat = 3;
        tx_q = '{8'hA5, 8'h5A, 8'hC3};
        do_start(1'b0, 16'h0200, 16'd3);
        wait_end("t3", 300);
        chk("t3_mem0200", 32'(mem[16'h0200]), 32'hA5);
        chk("t3_mem1200", 32'(mem[16'h1200]), 32'h5A);
        chk("t3_mem0201", 32'(mem[16'h0201]), 32'hC3);
        chk("t3_csum",    32'(checksum),      32'h01C2);
        chk("t3_done",    32'(done),          32'h1);

        // slave never acks
        tx_gap = 0; ack_lat = 1; never_ack = 1'b1;
        cyc_cycles = 0;
        tx_q = '{8'h66, 8'h77};
        do_start(1'b0, 16'h0300, 16'd2);
        wait_end("t4", 400);
        chk("t4_error",    32'(error),        32'h1);
        chk("t4_done",     32'(done),         32'h0);
        chk("t4_cyc",      32'(wb.wb_cyc_o),  32'h0);
        chk("t4_stb",      32'(wb.wb_stb_o),  32'h0);
        chk("t4_busy",     32'(busy),         32'h0);
        chk("t4_buscycles", 32'(cyc_cycles),  32'd255);
        chk("t4_leftover", 32'(tx_q.size()),  32'd1);

        // zero-length pass clears the error and completes immediately
        never_ack = 1'b0;
        tx_q.delete();
        wr0 = n_wr; rd0 = n_rd;
        do_start(1'b0, 16'h0000, 16'd0);
        chk("t5_done",  32'(done),  32'h1);
        chk("t5_error", 32'(error), 32'h0);
        chk("t5_busy",  32'(busy),  32'h0);
        repeat (5) @(posedge clk);
        #2;
        chk("t5_nobus", 32'((n_wr - wr0) + (n_rd - rd0)), 32'd0);

        // one-byte pass after the error
        tx_q = '{8'h99};
        do_start(1'b0, 16'h0310, 16'd1);
        wait_end("t5b", 50);
        chk("t5b_mem0310", 32'(mem[16'h0310]), 32'h99);
        chk("t5b_error",   32'(error),         32'h0);

        // start while busy is ignored
        tx_gap = 4;
        tx_q = '{8'h01, 8'h02};
        wr0 = n_wr;
        do_start(1'b0, 16'h0400, 16'd2);
        repeat (2) @(posedge clk);
        #2;
        chk("t6_busy", 32'(busy), 32'h1);
        do_start(1'b1, 16'h0500, 16'd0);
        wait_end("t6", 200);
        chk("t6_mem0400", 32'(mem[16'h0400]), 32'h01);
        chk("t6_mem1400", 32'(mem[16'h1400]), 32'h02);
        chk("t6_csum",    32'(checksum),      32'h0003);
        chk("t6_writes",  32'(n_wr - wr0),    32'd2);
        chk("t6_done",    32'(done),          32'h1);

        // reset in the middle of a bus cycle
        tx_gap = 0; never_ack = 1'b1;
        tx_q = '{8'hAB, 8'hCD, 8'hEF};
        do_start(1'b0, 16'h0600, 16'd3);
        k = 0;
        while (!wb.wb_cyc_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t7_cyc_seen", 32'(wb.wb_cyc_o), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t7_async_cyc",  32'(wb.wb_cyc_o), 32'h0);
        chk("t7_async_stb",  32'(wb.wb_stb_o), 32'h0);
        chk("t7_async_busy", 32'(busy),        32'h0);
        tx_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        never_ack = 1'b0;
        @(negedge clk);
        chk("t7_busy",    32'(busy),         32'h0);
        chk("t7_done",    32'(done),         32'h0);
        chk("t7_error",   32'(error),        32'h0);
        chk("t7_s_ready", 32'(s_ready),      32'h0);
        chk("t7_csum",    32'(checksum),     32'h0);
        chk("t7_mism",    32'(mismatch_cnt), 32'h0);
        chk("t7_adr",     32'(wb.wb_adr_o),  32'h0);

        // the loader still works from idle after reset
        tx_q = '{8'h5A};
        do_start(1'b0, 16'h0700, 16'd1);
        wait_end("t8", 50);
        chk("t8_mem0700", 32'(mem[16'h0700]), 32'h5A);
        chk("t8_csum",    32'(checksum),      32'h005A);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
